// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle datapath controller.
// Optional feature: define MULTICYCLE_CTRL_ADDI_EN to add the ADDIEX/ADDIWB states.
// Holds state enum, opcode constants, mux/ALU class encodings, fault codes.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
`ifdef MULTICYCLE_CTRL_ADDI_EN
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
`endif
    S_ERROR   = 4'd15
  } state_t;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALU control class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source mux
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B operand mux
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // Sticky fault codes
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // Bundle of datapath control strobes produced each cycle
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       retire;
  } ctrl_t;

  // States that wait on mem_ready and are covered by the timeout counter
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait counter: counts consecutive not-ready cycles in a wait state.
// expired is high during the MEM_TIMEOUT-th consecutive not-ready cycle, so
// the FSM leaves for ERROR on the edge where the count reaches MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == LAST);

  // Clear wins over count; saturate at LAST so the counter never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM with memory timeout and sticky fault code.
// Optional feature: define MULTICYCLE_CTRL_ADDI_EN to decode addi (opcode 001000).
// All outputs are forced to 0 while rst_n is low; ERROR holds until reset.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] state,
  output logic       retire,
  output logic [1:0] fault
);

  state_t     state_q, state_nxt;
  logic [1:0] fault_q, fault_nxt;
  ctrl_t      ctrl;
  logic       wait_cnt_en;
  logic       wait_clr;
  logic       wait_expired;
  logic       timeout;

  // mem_ready only matters in wait states; elsewhere it is ignored
  assign wait_cnt_en = is_wait_state(state_q) && !mem_ready;
  assign timeout     = wait_cnt_en && wait_expired;
  // Any state change clears the counter, so every wait state starts at 0
  assign wait_clr    = (state_nxt != state_q);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wait_clr),
    .count  (wait_cnt_en),
    .expired(wait_expired)
  );

  // State and sticky fault registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_nxt;
      fault_q <= fault_nxt;
    end
  end

  // Next-state and control decode; only FETCH/MEMWR look at mem_ready for strobes
  always_comb begin
    state_nxt = state_q;
    fault_nxt = fault_q;
    ctrl      = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ior_d     = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_nxt     = S_DECODE;
        end else if (timeout) begin
          state_nxt = S_ERROR;
          fault_nxt = FAULT_TIMEOUT;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_BRANCH;
        ctrl.alu_op    = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXECUTE;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
`ifdef MULTICYCLE_CTRL_ADDI_EN
          OP_ADDI:      state_nxt = S_ADDIEX;
`endif
          default: begin
            state_nxt = S_ERROR;
            fault_nxt = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_nxt      = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
        if (mem_ready) begin
          state_nxt = S_MEMWB;
        end else if (timeout) begin
          state_nxt = S_ERROR;
          fault_nxt = FAULT_TIMEOUT;
        end
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.retire     = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
        if (mem_ready) begin
          ctrl.retire = 1'b1;
          state_nxt   = S_FETCH;
        end else if (timeout) begin
          state_nxt = S_ERROR;
          fault_nxt = FAULT_TIMEOUT;
        end
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_nxt      = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.retire     = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.retire        = 1'b1;
        state_nxt          = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.retire    = 1'b1;
        state_nxt      = S_FETCH;
      end
`ifdef MULTICYCLE_CTRL_ADDI_EN
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_nxt      = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.retire     = 1'b1;
        state_nxt       = S_FETCH;
      end
`endif
      S_ERROR: begin
        state_nxt = S_ERROR;
      end
      default: begin
        // Unused encodings are treated as a dead end, same as ERROR
        state_nxt = S_ERROR;
      end
    endcase
  end

  // Strobes are gated by rst_n so FETCH's MemRead does not leak during reset
  assign PCWrite     = rst_n & ctrl.pc_write;
  assign PCWriteCond = rst_n & ctrl.pc_write_cond;
  assign IorD        = rst_n & ctrl.ior_d;
  assign MemRead     = rst_n & ctrl.mem_read;
  assign MemWrite    = rst_n & ctrl.mem_write;
  assign MemtoReg    = rst_n & ctrl.mem_to_reg;
  assign IRWrite     = rst_n & ctrl.ir_write;
  assign ALUSrcA     = rst_n & ctrl.alu_src_a;
  assign RegWrite    = rst_n & ctrl.reg_write;
  assign RegDst      = rst_n & ctrl.reg_dst;
  assign retire      = rst_n & ctrl.retire;
  assign PCSource    = rst_n ? ctrl.pc_source : 2'b00;
  assign ALUOp       = rst_n ? ctrl.alu_op    : 2'b00;
  assign ALUSrcB     = rst_n ? ctrl.alu_src_b : 2'b00;
  assign state       = state_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a reference model expands each
// instruction (opcode + memory wait counts) into its expected per-cycle trace.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  localparam int TMO = 15;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7,
                         BRANCH = 4'd8, JUMP = 4'd9, ADDIEX = 4'd10, ADDIWB = 4'd11,
                         ERR = 4'd15;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

`ifdef MULTICYCLE_CTRL_ADDI_EN
  localparam int N_LEGAL = 6;
`else
  localparam int N_LEGAL = 5;
`endif

  // Bit positions inside the 19-bit observation vector
  localparam int B_PCWC = 17, B_IRW = 12, B_RET = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       ALUSrcA, RegWrite, RegDst, retire;
  logic [1:0] PCSource, ALUOp, ALUSrcB, fault;
  logic [3:0] state;
  logic [18:0] dut_o;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .state(state), .retire(retire), .fault(fault)
  );

  always #5 clk = ~clk;

  assign dut_o = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                  ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, retire, fault};

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0]  exp_st[$];
  logic [18:0] exp_o[$];
  logic        stim_rdy[$];
  logic [5:0]  stim_op[$];
  logic [3:0]  obs_st[$];
  logic [18:0] obs_o[$];
  logic [1:0]  m_fault;
  bit          m_err;
  int          fill = -1;

  // ---------------- reference model ----------------
  // Per-state control table taken straight from the state descriptions
  function automatic logic [18:0] exp_outs(input logic [3:0] st, input logic rdy,
                                           input logic [1:0] flt);
    logic pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, ret;
    logic [1:0] pcs, aop, asb;
    {pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, ret} = 11'd0;
    pcs = 2'b00; aop = 2'b00; asb = 2'b00;
    case (st)
      FETCH:   begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
      DECODE:  begin asb = 2'b11; end
      MEMADR:  begin asa = 1'b1; asb = 2'b10; end
      MEMRD:   begin mr = 1'b1; iord = 1'b1; end
      MEMWB:   begin rw = 1'b1; m2r = 1'b1; ret = 1'b1; end
      MEMWR:   begin mw = 1'b1; iord = 1'b1; ret = rdy; end
      EXECUTE: begin asa = 1'b1; aop = 2'b10; end
      ALUWB:   begin rw = 1'b1; rd = 1'b1; ret = 1'b1; end
      BRANCH:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; ret = 1'b1; end
      JUMP:    begin pcw = 1'b1; pcs = 2'b10; ret = 1'b1; end
      ADDIEX:  begin asa = 1'b1; asb = 2'b10; end
      ADDIWB:  begin rw = 1'b1; ret = 1'b1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, pcs, aop, asb, ret, flt};
  endfunction

  function automatic logic rnd_rdy();
    if (fill < 0) return 1'($urandom_range(0, 1));
    return fill[0];
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
`ifdef MULTICYCLE_CTRL_ADDI_EN
    if (op == ADDI) return 1'b1;
`endif
    return (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == JMP);
  endfunction

  function automatic logic [5:0] pick_legal();
    int unsigned k;
    k = $urandom_range(0, N_LEGAL - 1);
    case (k)
      0: return LW;
      1: return SW;
      2: return RT;
      3: return BEQ;
      4: return JMP;
      default: return ADDI;
    endcase
  endfunction

  task automatic m_clear();
    exp_st.delete(); exp_o.delete(); stim_rdy.delete(); stim_op.delete();
    m_fault = 2'b00;
    m_err = 1'b0;
  endtask

  task automatic push(input logic [3:0] st, input logic rdy, input logic [5:0] op);
    exp_st.push_back(st);
    exp_o.push_back(exp_outs(st, rdy, m_fault));
    stim_rdy.push_back(rdy);
    stim_op.push_back(op);
  endtask

  // A memory wait: 'waits' not-ready cycles, then one ready cycle, unless the
  // wait reaches the timeout, in which case the next cycle is ERROR
  task automatic m_wait(input logic [3:0] st, input int waits, input logic [5:0] op);
    for (int i = 0; i < waits && i < TMO; i++) push(st, 1'b0, op);
    if (waits >= TMO) begin
      m_fault = 2'b10;
      m_err = 1'b1;
    end else begin
      push(st, 1'b1, op);
    end
  endtask

  task automatic m_instr(input logic [5:0] op, input int wf, input int wm);
    if (m_err) return;
    m_wait(FETCH, wf, op);
    if (m_err) return;
    push(DECODE, rnd_rdy(), op);
    case (op)
      LW: begin
        push(MEMADR, rnd_rdy(), op);
        m_wait(MEMRD, wm, op);
        if (!m_err) push(MEMWB, rnd_rdy(), op);
      end
      SW: begin
        push(MEMADR, rnd_rdy(), op);
        m_wait(MEMWR, wm, op);
      end
      RT: begin
        push(EXECUTE, rnd_rdy(), op);
        push(ALUWB, rnd_rdy(), op);
      end
      BEQ: push(BRANCH, rnd_rdy(), op);
      JMP: push(JUMP, rnd_rdy(), op);
`ifdef MULTICYCLE_CTRL_ADDI_EN
      ADDI: begin
        push(ADDIEX, rnd_rdy(), op);
        push(ADDIWB, rnd_rdy(), op);
      end
`endif
      default: begin
        m_fault = 2'b01;
        m_err = 1'b1;
      end
    endcase
  endtask

  task automatic m_err_cycles(input int n);
    if (m_err) begin
      for (int i = 0; i < n; i++) push(ERR, rnd_rdy(), 6'($urandom_range(0, 63)));
    end
  endtask

  // ---------------- drivers ----------------
  // Leaves time just after a rising edge with the first post-reset cycle starting
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic play();
    obs_st.delete(); obs_o.delete();
    for (int i = 0; i < stim_rdy.size(); i++) begin
      mem_ready = stim_rdy[i];
      opcode = stim_op[i];
      @(negedge clk);
      obs_st.push_back(state);
      obs_o.push_back(dut_o);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = LW;
    @(negedge clk);
    n_chk++;
    if (state !== FETCH) begin
      n_fail++; $display("FAIL reset_state: got %0d want %0d", state, FETCH);
    end
    n_chk++;
    if (dut_o !== 19'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want all zero", dut_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({state, dut_o} !== {FETCH, exp_outs(FETCH, 1'b0, 2'b00)}) begin
      n_fail++; $display("FAIL reset_release_fetch: got st=%0d o=%b want st=0 o=%b",
                         state, dut_o, exp_outs(FETCH, 1'b0, 2'b00));
    end
    mem_ready = 1'b1; #1;
    n_chk++;
    if (dut_o !== exp_outs(FETCH, 1'b1, 2'b00)) begin
      n_fail++; $display("FAIL fetch_handshake: got %b want %b", dut_o, exp_outs(FETCH, 1'b1, 2'b00));
    end
    @(posedge clk); #1;
    #2 rst_n = 1'b0; #1;
    n_chk++;
    if ({state, dut_o} !== {FETCH, 19'd0}) begin
      n_fail++; $display("FAIL async_reset_in_decode: got st=%0d o=%b want st=0 o=0", state, dut_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    int nret;
    m_clear(); fill = 1; m_instr(LW, 0, 0); fill = -1;
    do_reset(); play();
    for (int i = 0; i < exp_st.size(); i++) begin
      n_chk++;
      if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
        n_fail++;
        $display("FAIL lw_trace cycle %0d: got st=%0d o=%b want st=%0d o=%b",
                 i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
        break;
      end
    end
    nret = 0;
    foreach (obs_o[i]) nret += int'(obs_o[i][B_RET]);
    n_chk++;
    if (obs_st[4] !== MEMWB || obs_o[4][B_RET] !== 1'b1 || nret !== 1) begin
      n_fail++; $display("FAIL lw_retire_cycle5: got st=%0d retire=%b count=%0d want st=4 retire=1 count=1",
                         obs_st[4], obs_o[4][B_RET], nret);
    end
    for (int r = 0; r < 3; r++) begin
      m_clear(); m_instr(LW, $urandom_range(0, 4), $urandom_range(0, 6));
      do_reset(); play();
      for (int i = 0; i < exp_st.size(); i++) begin
        n_chk++;
        if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
          n_fail++;
          $display("FAIL lw_rand_trace run %0d cycle %0d: got st=%0d o=%b want st=%0d o=%b",
                   r, i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
          break;
        end
      end
    end
  endtask

  task automatic test_rtype_delay();
    int nirw;
    m_clear(); m_instr(RT, 3, 0);
    do_reset(); play();
    for (int i = 0; i < exp_st.size(); i++) begin
      n_chk++;
      if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
        n_fail++;
        $display("FAIL rtype_trace cycle %0d: got st=%0d o=%b want st=%0d o=%b",
                 i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
        break;
      end
    end
    nirw = 0;
    foreach (obs_o[i]) nirw += int'(obs_o[i][B_IRW]);
    n_chk++;
    if (nirw !== 1 || obs_o[3][B_IRW] !== 1'b1) begin
      n_fail++; $display("FAIL rtype_irwrite_once: got count=%0d cycle4=%b want count=1 cycle4=1",
                         nirw, obs_o[3][B_IRW]);
    end
    n_chk++;
    if (obs_st[6] !== ALUWB) begin
      n_fail++; $display("FAIL rtype_aluwb_cycle7: got st=%0d want %0d", obs_st[6], ALUWB);
    end
  endtask

  task automatic test_branch_jump();
    int wf;
    wf = $urandom_range(0, 3);
    m_clear(); m_instr(BEQ, wf, 0); m_instr(JMP, $urandom_range(0, 2), 0); m_instr(RT, 0, 0);
    do_reset(); play();
    for (int i = 0; i < exp_st.size(); i++) begin
      n_chk++;
      if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
        n_fail++;
        $display("FAIL branch_jump_trace cycle %0d: got st=%0d o=%b want st=%0d o=%b",
                 i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
        break;
      end
    end
    n_chk++;
    if (obs_st[wf + 2] !== BRANCH || obs_o[wf + 2][B_PCWC] !== 1'b1 || obs_o[wf + 2][8:5] !== 4'b0101) begin
      n_fail++; $display("FAIL beq_controls: got st=%0d pcwc=%b pcs_aluop=%b want st=8 pcwc=1 pcs_aluop=0101",
                         obs_st[wf + 2], obs_o[wf + 2][B_PCWC], obs_o[wf + 2][8:5]);
    end
    n_chk++;
    if (obs_st[wf + 3] !== FETCH) begin
      n_fail++; $display("FAIL beq_return_fetch: got st=%0d want 0", obs_st[wf + 3]);
    end
  endtask

  task automatic test_illegal();
    logic [5:0] op;
    bit quiet;
    for (int r = 0; r < 4; r++) begin
      if (r == 0) op = 6'b111111;
      else begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end
      m_clear(); m_instr(op, $urandom_range(0, 3), 0); m_err_cycles(20);
      do_reset(); play();
      for (int i = 0; i < exp_st.size(); i++) begin
        n_chk++;
        if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
          n_fail++;
          $display("FAIL illegal_trace op=%b cycle %0d: got st=%0d o=%b want st=%0d o=%b",
                   op, i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
          break;
        end
      end
      quiet = 1'b1;
      for (int i = obs_o.size() - 20; i < obs_o.size(); i++)
        if (obs_o[i][18:2] !== 17'd0 || obs_st[i] !== ERR) quiet = 1'b0;
      n_chk++;
      if (!quiet || obs_o[obs_o.size() - 1][1:0] !== 2'b01) begin
        n_fail++; $display("FAIL illegal_error_hold op=%b: quiet=%0d fault=%b want quiet=1 fault=01",
                           op, quiet, obs_o[obs_o.size() - 1][1:0]);
      end
    end
  endtask

  task automatic test_timeout();
    int nret;
    // Longest legal wait completes, then a store that times out
    m_clear(); m_instr(LW, $urandom_range(0, 3), TMO - 1); m_instr(SW, 0, TMO); m_err_cycles(5);
    do_reset(); play();
    for (int i = 0; i < exp_st.size(); i++) begin
      n_chk++;
      if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
        n_fail++;
        $display("FAIL timeout_sw_trace cycle %0d: got st=%0d o=%b want st=%0d o=%b",
                 i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
        break;
      end
    end
    nret = 0;
    foreach (obs_o[i]) nret += int'(obs_o[i][B_RET]);
    n_chk++;
    if (nret !== 1 || obs_o[obs_o.size() - 1][1:0] !== 2'b10) begin
      n_fail++; $display("FAIL timeout_sw_fault: retires=%0d fault=%b want retires=1 fault=10",
                         nret, obs_o[obs_o.size() - 1][1:0]);
    end
    // Instruction fetch that never completes
    m_clear(); m_instr(RT, TMO, 0); m_err_cycles(3);
    do_reset(); play();
    for (int i = 0; i < exp_st.size(); i++) begin
      n_chk++;
      if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
        n_fail++;
        $display("FAIL timeout_fetch_trace cycle %0d: got st=%0d o=%b want st=%0d o=%b",
                 i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
        break;
      end
    end
  endtask

  task automatic test_reset_mid();
    m_clear(); fill = 0;
    m_wait(FETCH, 0, LW); push(DECODE, 1'b0, LW); push(MEMADR, 1'b0, LW); push(MEMRD, 1'b0, LW);
    fill = -1;
    do_reset(); play();
    for (int i = 0; i < exp_st.size(); i++) begin
      n_chk++;
      if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
        n_fail++;
        $display("FAIL midreset_pre cycle %0d: got st=%0d o=%b want st=%0d o=%b",
                 i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
        break;
      end
    end
    mem_ready = 1'b1;
    #2 rst_n = 1'b0; #1;
    n_chk++;
    if ({state, dut_o} !== {FETCH, 19'd0}) begin
      n_fail++; $display("FAIL midreset_immediate: got st=%0d o=%b want st=0 o=0", state, dut_o);
    end
    @(negedge clk);
    n_chk++;
    if (retire !== 1'b0 || dut_o !== 19'd0) begin
      n_fail++; $display("FAIL midreset_held: got retire=%b o=%b want all zero", retire, dut_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_clear(); m_instr(SW, 1, 0);
    play();
    for (int i = 0; i < exp_st.size(); i++) begin
      n_chk++;
      if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
        n_fail++;
        $display("FAIL midreset_post cycle %0d: got st=%0d o=%b want st=%0d o=%b",
                 i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
        break;
      end
    end
  endtask

  task automatic test_addi();
    m_clear(); m_instr(ADDI, 1, 0); m_err_cycles(3); m_instr(JMP, 0, 0);
    do_reset(); play();
    for (int i = 0; i < exp_st.size(); i++) begin
      n_chk++;
      if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
        n_fail++;
        $display("FAIL addi_trace cycle %0d: got st=%0d o=%b want st=%0d o=%b",
                 i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
        break;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] op;
    m_clear();
    for (int k = 0; k < 15; k++) begin
      op = pick_legal();
      m_instr(op, ($urandom_range(0, 7) == 0) ? TMO - 1 : $urandom_range(0, 3), $urandom_range(0, 4));
    end
    do_reset(); play();
    for (int i = 0; i < exp_st.size(); i++) begin
      n_chk++;
      if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
        n_fail++;
        $display("FAIL back_to_back_trace cycle %0d: got st=%0d o=%b want st=%0d o=%b",
                 i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
        break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_delay();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_addi();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
